// File: rtl/wb_scoreboard_pkg.sv
// Shared defaults and the tag-slot record for the writeback scoreboard.
package wb_scoreboard_pkg;

  localparam int SB_PIPE_DEPTH = 3;
  localparam int SB_REG_ADDR_W = 3;
  localparam int SB_DATA_W     = 8;

  // One in-flight destination tag: valid marks a real register write.
  typedef struct packed {
    logic                     valid;
    logic [SB_REG_ADDR_W-1:0] dest;
  } slot_t;

endpackage

// File: rtl/wb_scoreboard_tag_pipe.sv
// Destination-tag shift register from EX to WB with per-slot source comparators.
module wb_tag_pipe
  import wb_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = SB_PIPE_DEPTH,
  parameter int REG_ADDR_W = SB_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loadValid,
  input  logic [REG_ADDR_W-1:0] loadDest,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
  output logic [PIPE_DEPTH-1:0] rs1Hit,
  output logic [PIPE_DEPTH-1:0] rs2Hit,
  output logic                  wbValid,
  output logic [REG_ADDR_W-1:0] wbDest
);

  slot_t slots [PIPE_DEPTH];

  // Shift every edge; the back end of the pipeline never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) slots[i] <= '0;
    end else begin
      slots[0] <= '{valid: loadValid, dest: loadDest};
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) slots[i] <= slots[i-1];
    end
  end

  // Per-slot match of both source addresses against valid tags.
  always_comb begin
    rs1Hit = '0;
    rs2Hit = '0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      rs1Hit[i] = slots[i].valid && (slots[i].dest == rs1Addr);
      rs2Hit[i] = slots[i].valid && (slots[i].dest == rs2Addr);
    end
  end

  assign wbValid = slots[PIPE_DEPTH-1].valid;
  assign wbDest  = slots[PIPE_DEPTH-1].dest;

endmodule

// File: rtl/wb_scoreboard.sv
// MEM/WB register, register-file write port and issue stall for stage 2.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = SB_PIPE_DEPTH,
  parameter int REG_ADDR_W = SB_REG_ADDR_W,
  parameter int DATA_W     = SB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs2_used,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_load_data,
  input  logic                  mem_wb_sel,
  output logic                  stall,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0]     regFileWriteData
);

  logic [PIPE_DEPTH-1:0] rs1Hit;
  logic [PIPE_DEPTH-1:0] rs2Hit;
  logic                  loadValid;
  logic [DATA_W-1:0]     wbData;

  // The WB slot is included in the hit vectors: reads are not write-through.
  assign stall     = issue_valid & ((rs1_used & (|rs1Hit)) | (rs2_used & (|rs2Hit)));
  assign loadValid = issue_valid & issue_writes & ~stall & ~flush;

  wb_tag_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) uTagPipe (
    .clk       (clk),
    .rst       (rst),
    .loadValid (loadValid),
    .loadDest  (issue_dest),
    .rs1Addr   (rs1_addr),
    .rs2Addr   (rs2_addr),
    .rs1Hit    (rs1Hit),
    .rs2Hit    (rs2Hit),
    .wbValid   (regWrite),
    .wbDest    (writeAddress)
  );

  // MEM/WB data register, loaded every edge alongside the tag moving into WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wbData <= '0;
    else     wbData <= mem_wb_sel ? mem_load_data : mem_alu_result;
  end

  assign regFileWriteData = wbData;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard.
module tb_wb_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_writes, rs1_used, rs2_used, flush, mem_wb_sel;
  logic [2:0] issue_dest, rs1_addr, rs2_addr, writeAddress;
  logic [7:0] mem_alu_result, mem_load_data, regFileWriteData;
  logic       stall, regWrite;

  int total = 0;
  int bad   = 0;

  wb_scoreboard #(.PIPE_DEPTH(3), .REG_ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .flush(flush), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_wb_sel(mem_wb_sel), .stall(stall), .regWrite(regWrite),
    .writeAddress(writeAddress), .regFileWriteData(regFileWriteData)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_writes = 0; issue_dest = 0;
    rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueWrite(input logic [2:0] d);
    idle();
    issue_valid = 1; issue_writes = 1; issue_dest = d;
  endtask

  task automatic reader1(input logic [2:0] a);
    idle();
    issue_valid = 1; rs1_addr = a; rs1_used = 1;
  endtask

  initial begin
    idle();
    mem_alu_result = 8'h00; mem_load_data = 8'h00; mem_wb_sel = 0;
    rst = 1;
    tick(); tick();
    chk("rst_regWrite", regWrite, 0);
    chk("rst_addr", writeAddress, 0);
    chk("rst_data", regFileWriteData, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    tick();

    // 1: reset mid-flight discards the in-flight R3 write
    issueWrite(3);
    tick();
    idle();
    mem_alu_result = 8'h33;
    tick();
    rst = 1;
    #1;
    chk("t1_rst_regWrite", regWrite, 0);
    tick();
    rst = 0;
    reader1(3);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t1_regWrite", regWrite, 0);
      chk("t1_stall", stall, 0);
      tick();
    end
    idle();
    tick();

    // 2: RAW on rs1, three stall cycles, write in the third
    issueWrite(3);
    #1 chk("t2_issue_stall", stall, 0);
    tick();                                 // edge 0
    idle(); rs1_addr = 3; rs1_used = 1;
    mem_alu_result = 8'hEE; mem_wb_sel = 0;
    #1 chk("t2_novalid_stall", stall, 0);
    issue_valid = 1;
    #1 chk("t2_c1_stall", stall, 1);
    chk("t2_c1_regWrite", regWrite, 0);
    tick();                                 // edge 1: producer in MEM
    mem_alu_result = 8'h5A;
    #1 chk("t2_c2_stall", stall, 1);
    tick();                                 // edge 2: producer in WB
    mem_alu_result = 8'h77;
    #1 chk("t2_c3_stall", stall, 1);
    chk("t2_c3_regWrite", regWrite, 1);
    chk("t2_c3_addr", writeAddress, 3);
    chk("t2_c3_data", regFileWriteData, 8'h5A);
    tick();                                 // edge 3: commit
    chk("t2_c4_stall", stall, 0);
    chk("t2_c4_regWrite", regWrite, 0);
    chk("t2_c4_data", regFileWriteData, 8'h77);
    tick();
    idle();

    // 3: load-data select
    issueWrite(5);
    tick();
    idle();
    mem_alu_result = 8'h99; mem_wb_sel = 0;
    tick();
    mem_wb_sel = 1; mem_load_data = 8'hC3; mem_alu_result = 8'h11;
    tick();
    chk("t3_regWrite", regWrite, 1);
    chk("t3_addr", writeAddress, 5);
    chk("t3_data", regFileWriteData, 8'hC3);
    mem_wb_sel = 0;
    tick();

    // 4: flushed write never lands and never blocks a reader
    issueWrite(2);
    flush = 1;
    #1 chk("t4_flush_stall", stall, 0);
    tick();
    reader1(2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_stall", stall, 0);
      chk("t4_regWrite", regWrite, 0);
      tick();
    end

    // 5: unused rs2 matching an in-flight dest does not stall
    issueWrite(4);
    tick();
    issueWrite(7);
    rs2_addr = 4; rs2_used = 0; rs1_addr = 1; rs1_used = 1;
    #1 chk("t5_stall", stall, 0);
    tick();
    idle();
    tick();
    chk("t5_w1_regWrite", regWrite, 1);
    chk("t5_w1_addr", writeAddress, 4);
    tick();
    chk("t5_w2_regWrite", regWrite, 1);
    chk("t5_w2_addr", writeAddress, 7);
    tick();
    chk("t5_done_regWrite", regWrite, 0);

    // register 0 is an ordinary register
    issueWrite(0);
    tick();
    idle(); issue_valid = 1; rs2_addr = 0; rs2_used = 1;
    #1 chk("t5_r0_stall", stall, 1);
    idle();
    tick(); tick(); tick();

    // 6: two in-flight writes to R6, reader waits for the younger one
    issueWrite(6);
    tick();                                 // A accepted
    issueWrite(6);
    #1 chk("t6_b_stall", stall, 0);
    tick();                                 // B accepted, A in MEM
    reader1(6);
    mem_alu_result = 8'h01;
    #1 chk("t6_c1_stall", stall, 1);
    tick();                                 // A in WB, B in MEM
    mem_alu_result = 8'h02;
    #1 chk("t6_c2_stall", stall, 1);
    chk("t6_c2_regWrite", regWrite, 1);
    chk("t6_c2_addr", writeAddress, 6);
    chk("t6_c2_data", regFileWriteData, 8'h01);
    tick();                                 // B in WB
    chk("t6_c3_stall", stall, 1);
    chk("t6_c3_regWrite", regWrite, 1);
    chk("t6_c3_addr", writeAddress, 6);
    chk("t6_c3_data", regFileWriteData, 8'h02);
    tick();                                 // B committed
    chk("t6_c4_stall", stall, 0);
    chk("t6_c4_regWrite", regWrite, 0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
